// File: rtl/score_counter_bcd_pkg.sv
// Shared constants and helpers for the BCD score counter: digit width,
// maximum decade count, strobe index width and BCD magnitude compare.
package score_pkg;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_W      = BCD_W * MAX_DIGITS;

    function automatic int calc_sw(input int digits);
        return (digits <= 2) ? 1 : $clog2(digits);
    endfunction

    // True when a > b; operands are zero-extended to MAX_DIGITS decades.
    function automatic logic bcd_gt(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
                gt      = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction
endpackage

// File: rtl/score_counter_bcd_digit.sv
// One BCD decade: increments on carry-in, rolls 9 -> 0 with carry-out,
// synchronous clear, and a hold input used for saturation at all-9s.
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             sat_hold_i,
    output logic [BCD_W-1:0] val_o,
    output logic             carry_o
);
    logic [BCD_W-1:0] val_q, val_d;

    assign carry_o = inc_i && (val_q == BCD_W'(9));

    always_comb begin
        val_d = val_q;
        if (clr_i)
            val_d = '0;
        else if (sat_hold_i)
            val_d = val_q;
        else if (inc_i)
            val_d = (val_q == BCD_W'(9)) ? '0 : val_q + BCD_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) val_q <= '0;
        else       val_q <= val_d;
    end

    assign val_o = val_q;
endmodule

// File: rtl/score_counter_bcd.sv
// Multi-digit BCD score counter with rising-edge scoring, overflow flag,
// retained high score and a multiplexed single-digit display output.
module score_counter_bcd
    import score_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STROBE_DIV = 100000,
    parameter bit SATURATE   = 1'b1,
    localparam int SW        = calc_sw(DIGITS),
    localparam int DW        = BCD_W * DIGITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             TARGET_REACHED,
    input  logic             CLEAR,
    input  logic             SHOW_HIGH,
    output logic [DW-1:0]    SCORE_BCD,
    output logic [DW-1:0]    HIGH_BCD,
    output logic [SW-1:0]    STROBE_COUNT,
    output logic [BCD_W-1:0] DIGIT_BCD,
    output logic             BLANK,
    output logic             OVERFLOW
);
    localparam int PW = $clog2(STROBE_DIV);

    logic            tr_q;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   high_q, high_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [SW-1:0]   strobe_q, strobe_d;
    logic [DW-1:0]   score;
    logic [DIGITS:0] carry;
    logic            sat_hold;

    // carry[DIGITS] is only set by an increment while every decade is 9.
    assign carry[0] = TARGET_REACHED && !tr_q && !CLEAR;
    assign sat_hold = SATURATE && carry[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (CLK),
            .rst_i      (RESET),
            .inc_i      (carry[g]),
            .clr_i      (CLEAR),
            .sat_hold_i (sat_hold),
            .val_o      (score[g*BCD_W +: BCD_W]),
            .carry_o    (carry[g+1])
        );
    end

    always_comb begin
        ovf_d = ovf_q;
        if (CLEAR)
            ovf_d = 1'b0;
        else if (carry[DIGITS])
            ovf_d = 1'b1;
    end

    // Compare against the registered score, so a CLEAR this cycle cannot hide a new maximum.
    always_comb begin
        high_d = high_q;
        if (bcd_gt(MAX_W'(score), MAX_W'(high_q)))
            high_d = score;
    end

    always_comb begin
        pre_d    = pre_q + PW'(1);
        strobe_d = strobe_q;
        if (pre_q == PW'(STROBE_DIV - 1)) begin
            pre_d    = '0;
            strobe_d = (strobe_q == SW'(DIGITS - 1)) ? '0 : strobe_q + SW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tr_q     <= 1'b0;
            ovf_q    <= 1'b0;
            high_q   <= '0;
            pre_q    <= '0;
            strobe_q <= '0;
        end else begin
            tr_q     <= TARGET_REACHED;
            ovf_q    <= ovf_d;
            high_q   <= high_d;
            pre_q    <= pre_d;
            strobe_q <= strobe_d;
        end
    end

    logic [MAX_W-1:0] src;
    logic             upper_nz;

    always_comb begin
        src      = SHOW_HIGH ? MAX_W'(high_q) : MAX_W'(score);
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(strobe_q)) && (src[i*BCD_W +: BCD_W] != '0))
                upper_nz = 1'b1;
        end
    end

    assign DIGIT_BCD    = src[int'(strobe_q)*BCD_W +: BCD_W];
    assign BLANK        = (strobe_q != '0) && !upper_nz;
    assign SCORE_BCD    = score;
    assign HIGH_BCD     = high_q;
    assign STROBE_COUNT = strobe_q;
    assign OVERFLOW     = ovf_q;
endmodule

// File: tb/tb_score_counter_bcd.sv
// Directed bench: saturating 4-digit, wrapping 4-digit and 3-digit counters
// share the stimulus; expectations are hand-computed constants.
module tb_score_counter_bcd;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TR = 1'b0;
    logic        CLEAR = 1'b0;
    logic        SHOW_HIGH = 1'b0;

    logic [15:0] score_s, high_s, score_w, high_w;
    logic [11:0] score_3, high_3;
    logic [1:0]  strobe_s, strobe_w, strobe_3;
    logic [3:0]  digit_s, digit_w, digit_3;
    logic        blank_s, blank_w, blank_3;
    logic        ovf_s, ovf_w, ovf_3;

    int ncmp = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    score_counter_bcd #(.DIGITS(4), .STROBE_DIV(4), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TR), .CLEAR(CLEAR), .SHOW_HIGH(SHOW_HIGH),
        .SCORE_BCD(score_s), .HIGH_BCD(high_s), .STROBE_COUNT(strobe_s),
        .DIGIT_BCD(digit_s), .BLANK(blank_s), .OVERFLOW(ovf_s));

    score_counter_bcd #(.DIGITS(4), .STROBE_DIV(4), .SATURATE(1'b0)) u_wrap (
        .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TR), .CLEAR(CLEAR), .SHOW_HIGH(SHOW_HIGH),
        .SCORE_BCD(score_w), .HIGH_BCD(high_w), .STROBE_COUNT(strobe_w),
        .DIGIT_BCD(digit_w), .BLANK(blank_w), .OVERFLOW(ovf_w));

    score_counter_bcd #(.DIGITS(3), .STROBE_DIV(4), .SATURATE(1'b1)) u_d3 (
        .CLK(CLK), .RESET(RESET), .TARGET_REACHED(TR), .CLEAR(CLEAR), .SHOW_HIGH(SHOW_HIGH),
        .SCORE_BCD(score_3), .HIGH_BCD(high_3), .STROBE_COUNT(strobe_3),
        .DIGIT_BCD(digit_3), .BLANK(blank_3), .OVERFLOW(ovf_3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            TR = 1'b1; tick();
            TR = 1'b0; tick();
        end
    endtask

    task automatic wait_slot(input logic [1:0] s);
        int n = 0;
        while (strobe_s !== s && n < 20) begin
            tick();
            n++;
        end
        chk("wait_slot", 32'(strobe_s), 32'(s));
    endtask

    initial begin
        int exp_d[4] = '{2, 4, 0, 0};
        int exp_b[4] = '{0, 0, 1, 1};
        logic [1:0] prev3;
        int wraps3;

        // Power-on reset, then idle
        #12;
        chk("por_score", 32'(score_s), 32'h0);
        chk("por_strobe", 32'(strobe_s), 32'h0);
        RESET = 1'b0;
        repeat (20) tick();
        chk("idle_score", 32'(score_s), 32'h0000);

        // Held-high input scores once
        TR = 1'b1;
        repeat (10) tick();
        chk("held_score", 32'(score_s), 32'h0001);
        TR = 1'b0; tick();

        // Carry across decades and high-score latency
        pulse(98);
        chk("pre_carry", 32'(score_s), 32'h0099);
        TR = 1'b1; tick();
        chk("carry_score", 32'(score_s), 32'h0100);
        chk("high_lag", 32'(high_s), 32'h0099);
        TR = 1'b0; tick();
        chk("high_follow", 32'(high_s), 32'h0100);

        // All-9s boundary in both modes
        pulse(9899);
        chk("sat_9999", 32'(score_s), 32'h9999);
        chk("wrap_9999", 32'(score_w), 32'h9999);
        chk("ovf_before", 32'(ovf_s), 32'h0);
        pulse(1);
        chk("sat_hold", 32'(score_s), 32'h9999);
        chk("sat_ovf", 32'(ovf_s), 32'h1);
        chk("wrap_zero", 32'(score_w), 32'h0000);
        chk("wrap_ovf", 32'(ovf_w), 32'h1);

        // CLEAR drops the score and overflow but keeps the high score
        CLEAR = 1'b1; tick();
        CLEAR = 1'b0;
        chk("clr_score", 32'(score_s), 32'h0000);
        chk("clr_ovf", 32'(ovf_s), 32'h0);
        chk("clr_high", 32'(high_s), 32'h9999);
        pulse(3);
        chk("post_clr", 32'(score_s), 32'h0003);

        // Asynchronous reset mid-clock, input held high across release
        #3;
        RESET = 1'b1;
        TR = 1'b1;
        #1;
        chk("arst_score", 32'(score_s), 32'h0);
        chk("arst_high", 32'(high_s), 32'h0);
        chk("arst_high_w", 32'(high_w), 32'h0);
        chk("arst_strobe", 32'(strobe_s), 32'h0);
        tick();
        RESET = 1'b0;
        tick();
        chk("rel_held", 32'(score_s), 32'h0001);
        TR = 1'b0; tick();
        pulse(41);
        chk("score_42", 32'(score_s), 32'h0042);
        chk("high_42", 32'(high_s), 32'h0042);

        // Multiplex and leading-zero blanking, 4 clocks per slot
        wait_slot(2'd3);
        wait_slot(2'd0);
        for (int s = 0; s < 4; s++) begin
            chk("slot_idx", 32'(strobe_s), 32'(s));
            chk("slot_digit", 32'(digit_s), 32'(exp_d[s]));
            chk("slot_blank", 32'(blank_s), 32'(exp_b[s]));
            repeat (3) tick();
            chk("slot_hold", 32'(strobe_s), 32'(s));
            tick();
        end
        chk("slot_wrap", 32'(strobe_s), 32'h0);

        // CLEAR wins over a simultaneous rising edge
        TR = 1'b1; CLEAR = 1'b1; tick();
        TR = 1'b0; CLEAR = 1'b0;
        chk("prio_score", 32'(score_s), 32'h0000);
        chk("prio_ovf", 32'(ovf_s), 32'h0);
        tick();
        chk("prio_high", 32'(high_s), 32'h0042);

        // SHOW_HIGH switches the display source without a clock
        wait_slot(2'd1);
        chk("cur_digit", 32'(digit_s), 32'h0);
        chk("cur_blank", 32'(blank_s), 32'h1);
        SHOW_HIGH = 1'b1;
        #1;
        chk("hi_digit1", 32'(digit_s), 32'h4);
        chk("hi_blank1", 32'(blank_s), 32'h0);
        wait_slot(2'd0);
        chk("hi_digit0", 32'(digit_s), 32'h2);
        SHOW_HIGH = 1'b0;

        // Three-digit strobe: 0,1,2,0 and never 3
        prev3 = strobe_3;
        wraps3 = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (strobe_3 !== prev3) begin
                chk("d3_step", 32'(strobe_3), (prev3 == 2'd2) ? 32'h0 : 32'(prev3 + 2'd1));
                if (prev3 == 2'd2) wraps3++;
            end
            prev3 = strobe_3;
        end
        chk("d3_wrapped", 32'(wraps3 >= 2), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
